// File: rtl/mem_access_stage.sv
// mem_access_stage: LC-3b memory-stage controller.
// Sequences LDW/LDB/STW/STB and the two-access LDI/STI, holds the pipeline
// in stall until the data memory responds, and presents aligned,
// sign-extended load data for the MEM/WB register.
//
// Ports:
//   clk, reset          pipeline clock, synchronous active-high reset
//   in_valid            EX/MEM slot holds a valid instruction
//   in_opcode[3:0]      opcode of the EX/MEM instruction
//   in_address[15:0]    effective address from EX
//   in_wdata[15:0]      store data (SR value)
//   dmem_resp           data memory completed the current request
//   dmem_rdata[15:0]    data memory read word
//   dmem_read/write     request strobes, decoded from state
//   dmem_address[15:0]  word-aligned request address
//   dmem_wdata[15:0]    write data
//   dmem_byte_enable    bit1 = high byte, bit0 = low byte
//   mem_rdata[15:0]     final load data
//   mem_stall           freeze all pipeline registers
//
// state  | meaning
// IDLE   | no access in flight; a memory op stalls and moves to FIRST
// FIRST  | access at in_address (pointer fetch for LDI/STI)
// SECOND | indirect access at the latched pointer
// DONE   | stall released for one cycle, pipeline advances
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  in_opcode,
  input  logic [15:0] in_address,
  input  logic [15:0] in_wdata,
  input  logic        dmem_resp,
  input  logic [15:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] mem_rdata,
  output logic        mem_stall
);

  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_LDW = 4'b0110;
  localparam logic [3:0] OP_STW = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;

  state_t      state;
  logic [15:1] ptr;

  logic        is_ldb, is_stb, is_ldw, is_stw, is_ldi, is_sti;
  logic        is_mem, is_ind, is_byte;
  logic [7:0]  load_byte;
  logic [15:0] load_data;

  always_comb begin
    is_ldb  = in_valid && (in_opcode == OP_LDB);
    is_stb  = in_valid && (in_opcode == OP_STB);
    is_ldw  = in_valid && (in_opcode == OP_LDW);
    is_stw  = in_valid && (in_opcode == OP_STW);
    is_ldi  = in_valid && (in_opcode == OP_LDI);
    is_sti  = in_valid && (in_opcode == OP_STI);
    is_ind  = is_ldi || is_sti;
    is_byte = is_ldb || is_stb;
    is_mem  = is_ldb || is_stb || is_ldw || is_stw || is_ind;
    load_byte = in_address[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
    load_data = is_ldb ? {{8{load_byte[7]}}, load_byte} : dmem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      mem_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (is_mem) state <= FIRST;
        FIRST:
          if (dmem_resp) begin
            if (is_ind) begin
              ptr   <= dmem_rdata[15:1];
              state <= SECOND;
            end else begin
              if (is_ldw || is_ldb) mem_rdata <= load_data;
              state <= DONE;
            end
          end
        SECOND:
          if (dmem_resp) begin
            if (is_ldi) mem_rdata <= dmem_rdata;
            state <= DONE;
          end
        default: state <= IDLE;
      endcase
    end
  end

  // Request outputs come straight from state so a request starts the cycle
  // the state is entered and drops the cycle after the response.
  always_comb begin
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = {in_address[15:1], 1'b0};
    dmem_wdata       = in_wdata;
    dmem_byte_enable = 2'b11;
    mem_stall        = 1'b0;
    case (state)
      IDLE: mem_stall = is_mem;
      FIRST: begin
        mem_stall  = 1'b1;
        dmem_read  = is_ldw || is_ldb || is_ind;
        dmem_write = is_stw || is_stb;
        if (is_byte) dmem_byte_enable = in_address[0] ? 2'b10 : 2'b01;
        if (is_stb) dmem_wdata = {in_wdata[7:0], in_wdata[7:0]};
      end
      SECOND: begin
        mem_stall    = 1'b1;
        dmem_address = {ptr, 1'b0};
        dmem_read    = is_ldi;
        dmem_write   = is_sti;
      end
      default: mem_stall = 1'b0;
    endcase
  end

endmodule
